// File: rtl/bcd_down_cnt.sv
// -----------------------------------------------------------------------------
// bcd_down_cnt
//
// Synchronous multi-digit BCD down counter with parallel preset, zero flag
// and borrow-out for cascading. Count range is 0 .. 10^DIGITS-1.
//
// Parameters:
//   DIGITS  number of BCD digits (1..4)
//
// Ports:
//   CK      clock, all state updates on the rising edge
//   nClear  synchronous active-low clear (highest priority)
//   EN      count enable, decrement by one per enabled edge
//   LOAD    parallel load strobe (wins over EN)
//   D       BCD preset, digit i in D[4i+3:4i], digit 0 least significant
//   Q       current BCD count (registered)
//   ZERO    Q is all-zero digits (combinational from Q)
//   BO      borrow out = EN & ZERO & ~LOAD, feeds EN of the next instance
//   ERR     last load contained a nibble 10..15 (coerced to 9)
//
// Build option:
//   BCD_DOWN_SATURATE_EN  when defined, the count holds at zero instead of
//                         wrapping to 9...9, and BO is tied low.
// -----------------------------------------------------------------------------
module bcd_down_cnt #(
  parameter int DIGITS = 2
) (
  input  logic                CK,
  input  logic                nClear,
  input  logic                EN,
  input  logic                LOAD,
  input  logic [4*DIGITS-1:0] D,
  output logic [4*DIGITS-1:0] Q,
  output logic                ZERO,
  output logic                BO,
  output logic                ERR
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]      q_reg;
  logic [W-1:0]      q_next;
  logic              err_reg;
  logic              err_next;
  logic [W-1:0]      load_val;
  logic [W-1:0]      dec_val;
  logic [DIGITS-1:0] coerced;
  logic              zero_flag;
  logic              dec_en;

  assign zero_flag = (q_reg == '0);

`ifdef BCD_DOWN_SATURATE_EN
  // Stop at zero: suppress the decrement so the count does not wrap.
  assign dec_en = EN & ~zero_flag;
  assign BO     = 1'b0;
`else
  assign dec_en = EN;
  assign BO     = EN & zero_flag & ~LOAD;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] d_nib;
      logic [3:0] q_nib;
      logic       borrow_in;

      assign d_nib = D[4*gi +: 4];
      assign q_nib = q_reg[4*gi +: 4];

      // Non-BCD preset nibbles are clamped to 9 so Q never leaves 0..9.
      assign coerced[gi]           = (d_nib > 4'd9);
      assign load_val[4*gi +: 4]   = coerced[gi] ? 4'd9 : d_nib;

      // A digit sees a borrow exactly when the decrement is enabled and every
      // lower digit is zero; computing it directly avoids a rippling chain.
      if (gi == 0) begin : g_lsd
        assign borrow_in = dec_en;
      end else begin : g_upper
        assign borrow_in = dec_en & (q_reg[4*gi-1:0] == '0);
      end

      assign dec_val[4*gi +: 4] = !borrow_in        ? q_nib :
                                  (q_nib == 4'd0)   ? 4'd9  :
                                                      q_nib - 4'd1;
    end
  endgenerate

  always_comb begin
    q_next   = q_reg;
    err_next = err_reg;
    if (LOAD) begin
      q_next   = load_val;
      err_next = |coerced;
    end else if (EN) begin
      q_next = dec_val;
    end
  end

  always_ff @(posedge CK) begin
    if (!nClear) begin
      q_reg   <= '0;
      err_reg <= 1'b0;
    end else begin
      q_reg   <= q_next;
      err_reg <= err_next;
    end
  end

  assign Q    = q_reg;
  assign ZERO = zero_flag;
  assign ERR  = err_reg;

endmodule

// File: tb/tb_bcd_down_cnt.sv
// -----------------------------------------------------------------------------
// tb_bcd_down_cnt
//
// Self-checking bench for bcd_down_cnt (DIGITS=2). Expected Q/ERR values are
// pushed to a scoreboard when stimulus is driven and popped after the edge.
// ZERO and BO are checked combinationally before each edge.
// -----------------------------------------------------------------------------
module tb_bcd_down_cnt;

  localparam int DIGITS = 2;
  localparam int W      = 4 * DIGITS;

`ifdef BCD_DOWN_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         CK = 1'b0;
  logic         nClear;
  logic         EN;
  logic         LOAD;
  logic [W-1:0] D;
  logic [W-1:0] Q;
  logic         ZERO;
  logic         BO;
  logic         ERR;

  int checks = 0;
  int fails  = 0;

  logic [W-1:0] exp_q_queue[$];
  logic         exp_err_queue[$];

  // values popped by advance()
  logic [W-1:0] exp_q;
  logic         exp_err;
  logic         have_exp;

  bcd_down_cnt #(.DIGITS(DIGITS)) dut (
    .CK     (CK),
    .nClear (nClear),
    .EN     (EN),
    .LOAD   (LOAD),
    .D      (D),
    .Q      (Q),
    .ZERO   (ZERO),
    .BO     (BO),
    .ERR    (ERR)
  );

  always #5 CK = ~CK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic [W-1:0] q, input logic e);
    exp_q_queue.push_back(q);
    exp_err_queue.push_back(e);
  endtask

  // One clock edge, then pop the scoreboard entry for it.
  task automatic advance();
    @(posedge CK);
    #1;
    if (exp_q_queue.size() == 0) begin
      have_exp = 1'b0;
      exp_q    = '0;
      exp_err  = 1'b0;
    end else begin
      have_exp = 1'b1;
      exp_q    = exp_q_queue.pop_front();
      exp_err  = exp_err_queue.pop_front();
    end
  endtask

  task automatic drive(input logic nc, input logic ld, input logic en, input logic [W-1:0] d);
    nClear = nc;
    LOAD   = ld;
    EN     = en;
    D      = d;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    drive(1'b0, 1'b1, 1'b1, 8'h57);
    push_exp(8'h00, 1'b0);
    advance();
    checks++;
    if (!have_exp || Q !== exp_q || ERR !== exp_err) begin
      fails++;
      $display("FAIL reset_state: got Q=%h ERR=%b, required Q=%h ERR=%b", Q, ERR, exp_q, exp_err);
    end
    checks++;
    if (ZERO !== 1'b1 || BO !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags_load: got ZERO=%b BO=%b, required ZERO=1 BO=0", ZERO, BO);
    end
    LOAD = 1'b0;
    #1;
    checks++;
    if (BO !== !SAT) begin
      fails++;
      $display("FAIL reset_bo: got BO=%b, required BO=%b", BO, !SAT);
    end
    // Reset must also clear a set ERR.
    drive(1'b1, 1'b1, 1'b0, 8'hC3);
    push_exp(8'h93, 1'b1);
    advance();
    checks++;
    if (!have_exp || Q !== exp_q || ERR !== exp_err) begin
      fails++;
      $display("FAIL reset_preload: got Q=%h ERR=%b, required Q=%h ERR=%b", Q, ERR, exp_q, exp_err);
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    push_exp(8'h00, 1'b0);
    advance();
    checks++;
    if (!have_exp || Q !== exp_q || ERR !== exp_err) begin
      fails++;
      $display("FAIL reset_clears_err: got Q=%h ERR=%b, required Q=%h ERR=%b", Q, ERR, exp_q, exp_err);
    end
    $display("test_reset: Q=%h ERR=%b", Q, ERR);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_load_count();
    logic [W-1:0] seq [3];
    seq = '{8'h11, 8'h10, 8'h09};
    drive(1'b1, 1'b1, 1'b0, 8'h12);
    push_exp(8'h12, 1'b0);
    advance();
    checks++;
    if (!have_exp || Q !== exp_q || ERR !== exp_err) begin
      fails++;
      $display("FAIL load_12: got Q=%h ERR=%b, required Q=%h ERR=%b", Q, ERR, exp_q, exp_err);
    end
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) begin
      push_exp(seq[i], 1'b0);
      advance();
      checks++;
      if (!have_exp || Q !== exp_q || ERR !== exp_err) begin
        fails++;
        $display("FAIL count_%0d: got Q=%h ERR=%b, required Q=%h ERR=%b", i, Q, ERR, exp_q, exp_err);
      end
      $display("test_load_count: step %0d Q=%h", i, Q);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_wrap();
    drive(1'b1, 1'b1, 1'b0, 8'h01);
    push_exp(8'h01, 1'b0);
    advance();
    checks++;
    if (!have_exp || Q !== exp_q) begin
      fails++;
      $display("FAIL wrap_load: got Q=%h, required Q=%h", Q, exp_q);
    end
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    push_exp(8'h00, 1'b0);
    advance();
    checks++;
    if (!have_exp || Q !== exp_q || ZERO !== 1'b1 || BO !== !SAT) begin
      fails++;
      $display("FAIL wrap_zero: got Q=%h ZERO=%b BO=%b, required Q=%h ZERO=1 BO=%b",
               Q, ZERO, BO, exp_q, !SAT);
    end
    push_exp(SAT ? 8'h00 : 8'h99, 1'b0);
    advance();
    checks++;
    if (!have_exp || Q !== exp_q || BO !== 1'b0 || ZERO !== SAT) begin
      fails++;
      $display("FAIL wrap_next: got Q=%h ZERO=%b BO=%b, required Q=%h ZERO=%b BO=0",
               Q, ZERO, BO, exp_q, SAT);
    end
    $display("test_wrap: Q=%h BO=%b", Q, BO);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_invalid_load();
    drive(1'b1, 1'b1, 1'b0, 8'h3C);
    push_exp(8'h39, 1'b1);
    advance();
    checks++;
    if (!have_exp || Q !== exp_q || ERR !== exp_err) begin
      fails++;
      $display("FAIL invalid_3C: got Q=%h ERR=%b, required Q=%h ERR=%b", Q, ERR, exp_q, exp_err);
    end
    // ERR holds while counting
    drive(1'b1, 1'b0, 1'b1, 8'h00);
    push_exp(8'h38, 1'b1);
    advance();
    checks++;
    if (!have_exp || Q !== exp_q || ERR !== exp_err) begin
      fails++;
      $display("FAIL err_hold_count: got Q=%h ERR=%b, required Q=%h ERR=%b", Q, ERR, exp_q, exp_err);
    end
    drive(1'b1, 1'b1, 1'b0, 8'h05);
    push_exp(8'h05, 1'b0);
    advance();
    checks++;
    if (!have_exp || Q !== exp_q || ERR !== exp_err) begin
      fails++;
      $display("FAIL valid_05: got Q=%h ERR=%b, required Q=%h ERR=%b", Q, ERR, exp_q, exp_err);
    end
    $display("test_invalid_load: Q=%h ERR=%b", Q, ERR);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_priority_hold();
    drive(1'b1, 1'b1, 1'b1, 8'h40);
    push_exp(8'h40, 1'b0);
    advance();
    checks++;
    if (!have_exp || Q !== exp_q) begin
      fails++;
      $display("FAIL load_over_en: got Q=%h, required Q=%h", Q, exp_q);
    end
    drive(1'b1, 1'b0, 1'b0, 8'h77);
    for (int i = 0; i < 5; i++) begin
      push_exp(8'h40, 1'b0);
      advance();
      checks++;
      if (!have_exp || Q !== exp_q || ERR !== exp_err) begin
        fails++;
        $display("FAIL hold_%0d: got Q=%h ERR=%b, required Q=%h ERR=%b", i, Q, ERR, exp_q, exp_err);
      end
    end
    $display("test_priority_hold: Q=%h", Q);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_mid_reset();
    logic [W-1:0] seq [5];
    logic [4:0]   ncl;
    seq = '{8'h46, 8'h45, 8'h00, (SAT ? 8'h00 : 8'h99), (SAT ? 8'h00 : 8'h98)};
    ncl = 5'b11011;
    drive(1'b1, 1'b1, 1'b0, 8'h47);
    push_exp(8'h47, 1'b0);
    advance();
    checks++;
    if (!have_exp || Q !== exp_q) begin
      fails++;
      $display("FAIL midreset_load: got Q=%h, required Q=%h", Q, exp_q);
    end
    for (int i = 0; i < 5; i++) begin
      drive(ncl[4-i], 1'b0, 1'b1, 8'h00);
      push_exp(seq[i], 1'b0);
      advance();
      checks++;
      if (!have_exp || Q !== exp_q || ERR !== exp_err) begin
        fails++;
        $display("FAIL midreset_%0d: got Q=%h ERR=%b, required Q=%h ERR=%b", i, Q, ERR, exp_q, exp_err);
      end
      $display("test_mid_reset: step %0d nClear=%b Q=%h", i, ncl[4-i], Q);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Randomised run against an integer-arithmetic reference model.
  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic test_random();
    logic [W-1:0] m_q;
    logic         m_err;
    logic         nc, ld, en;
    logic [W-1:0] d;
    int           modulus = 1;
    for (int i = 0; i < DIGITS; i++) modulus = modulus * 10;
    m_q   = Q;     // state carried over from the previous scenario
    m_err = ERR;
    if (m_q !== 8'h98 && m_q !== 8'h00) begin
      // previous scenario already reports this; resync via reset
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      @(posedge CK); #1;
      m_q = '0; m_err = 1'b0;
    end
    for (int n = 0; n < 60; n++) begin
      nc = ($urandom_range(0, 15) != 0);
      ld = ($urandom_range(0, 5) == 0);
      en = ($urandom_range(0, 3) != 0);
      d  = W'($urandom);
      drive(nc, ld, en, d);
      #1;
      checks++;
      if (ZERO !== (m_q == '0) || BO !== (en & (m_q == '0) & ~ld & ~SAT)) begin
        fails++;
        $display("FAIL rand_flags_%0d: got ZERO=%b BO=%b, required ZERO=%b BO=%b",
                 n, ZERO, BO, (m_q == '0), (en & (m_q == '0) & ~ld & ~SAT));
      end
      if (!nc) begin
        m_q = '0; m_err = 1'b0;
      end else if (ld) begin
        m_err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
          if (d[4*i +: 4] > 4'd9) begin
            m_q[4*i +: 4] = 4'd9;
            m_err = 1'b1;
          end else begin
            m_q[4*i +: 4] = d[4*i +: 4];
          end
        end
      end else if (en) begin
        if (!(SAT && bcd2int(m_q) == 0))
          m_q = int2bcd((bcd2int(m_q) + modulus - 1) % modulus);
      end
      push_exp(m_q, m_err);
      advance();
      checks++;
      if (!have_exp || Q !== exp_q || ERR !== exp_err) begin
        fails++;
        $display("FAIL rand_%0d: got Q=%h ERR=%b, required Q=%h ERR=%b", n, Q, ERR, exp_q, exp_err);
      end
      $display("test_random: %0d nClear=%b LOAD=%b EN=%b D=%h Q=%h ERR=%b", n, nc, ld, en, d, Q, ERR);
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, '0);
    @(negedge CK);
    test_reset();
    test_load_count();
    test_wrap();
    test_invalid_load();
    test_priority_hold();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/bcd_down_cnt.md
Name: bcd_down_cnt

Overview:
- Synchronous multi-digit BCD down counter. It is the count-down counterpart of the team's BCD up counter.
- Used as a countdown timer or terminal-count divider. Presets from a parallel BCD load, decrements by one per enabled clock, flags zero.
- Emits a borrow for cascading further instances.
- All state is in one clock domain. Reset uses the codebase's clear naming, synchronous and active-low.

Parameters:
- DIGITS, 2, number of BCD digits (1..4). Count range is 0 to 10^DIGITS-1.

Ports:
- CK  input  1  clock; all state updates on rising edge
- nClear  input  1  synchronous active-low reset; sampled on rising edge of CK
- EN  input  1  count enable; decrement by one when high
- LOAD  input  1  parallel load strobe
- D  input  4*DIGITS  BCD preset value; digit i in D[4i+3:4i], digit 0 = least significant
- Q  output  4*DIGITS  current BCD count, registered
- ZERO  output  1  high when Q equals all-zero digits (combinational from Q)
- BO  output  1  borrow out, = EN & ZERO & ~LOAD (combinational); drives EN of the next-higher instance
- ERR  output  1  registered flag: last load contained a non-BCD nibble

Behaviour:
- Reset: nClear low at a CK rising edge sets Q=0 and ERR=0. As a result ZERO=1, and BO=EN&~LOAD. Reset has top priority and overrides LOAD and EN.
- Reset mid-operation: the count is abandoned and Q=0 from the next edge. No partial-digit state survives.
- Priority when nClear is high: LOAD > EN > hold.
- LOAD=1: Q takes D after the edge (1-cycle latency); EN is ignored that cycle.
  - Any nibble of D with value 10..15 is loaded as 9 (digit coerced to 9).
  - ERR is set to 1 if any nibble was coerced, otherwise ERR is cleared to 0.
- EN=1, LOAD=0: Q = Q-1 in BCD.
  - Digit 0 decrements. If it was 0, it becomes 9 and borrows from digit 1, and so on up the chain.
  - A borrow out of the top digit wraps the whole count: 0...0 -> 9...9 (e.g. DIGITS=2: 00 -> 99).
  - ERR is unchanged.
- EN=0, LOAD=0: Q and ERR hold.
- Digit decrement rule per digit, with borrow-in b:
  - If b=0: digit unchanged.
  - If b=1 and digit=0: digit becomes 9 and borrow-out is 1.
  - Otherwise: digit-1, borrow-out 0.
  - Borrow-in to digit 0 is EN.
- Q never holds a non-BCD nibble. Reset, load coercion and the decrement rule keep every digit in 0..9.
- BO is asserted during the same cycle in which the count is 0 and a decrement is about to occur. Cascading: the upper instance decrements on the same edge on which the lower one wraps to 9...9.
- No internal state machine beyond the count and ERR registers. No gated or derived clocks; all flops are clocked directly by CK.

Optional Feature:
- Macro BCD_DOWN_SATURATE_EN.
- Defined:
  - With EN=1, LOAD=0 and Q=0, Q holds at 0 and does not wrap.
  - BO is forced to 0, so no cascade borrow.
  - A new LOAD is required to restart the count.
- Undefined: wrap-around and BO behave as described under Behaviour.

Test Plan:
- Reset: hold nClear=0 for 1 edge with LOAD=1, D=0x57, EN=1 -> Q=0x00, ZERO=1, ERR=0; LOAD ignored.
- Load and count (DIGITS=2): LOAD D=0x12, then EN=1 for 3 edges -> Q sequence 0x12, 0x11, 0x10, 0x09 (inter-digit borrow at 10->09).
- Wrap: LOAD D=0x01, EN=1 for 2 edges -> Q 0x01, 0x00 with ZERO=1 and BO=1 during the 00 cycle, then 0x99 and BO=0. With BCD_DOWN_SATURATE_EN defined -> Q stays 0x00 and BO=0.
- Invalid load: LOAD D=0x3C -> Q=0x39, ERR=1. Next LOAD D=0x05 -> Q=0x05, ERR=0.
- Priority and hold: LOAD=1 and EN=1 together with D=0x40 -> Q=0x40 (no decrement). EN=0, LOAD=0 for 5 edges -> Q stays 0x40.
- Mid-count reset: from Q=0x47 counting with EN=1, pulse nClear=0 for one edge -> Q=0x00 next cycle. Counting resumes 0x99, 0x98 with EN still high.
